// File: rtl/mips_mem_pkg.sv
// Shared opcode, access-size and FSM definitions for the MEM-stage data-memory controller.
package mips_mem_pkg;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic [1:0] op_size(input logic [5:0] op);
      logic [1:0] sz;
      case (op)
         OP_LB, OP_LBU, OP_SB: sz = SIZE_B;
         OP_LH, OP_LHU, OP_SH: sz = SIZE_H;
         default:              sz = SIZE_W;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data alignment: selects the addressed byte/half of the raw
// little-endian read word and sign- or zero-extends it to 32 bits.
module load_align
   import mips_mem_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [31:0] shifted;

   // Halfword loads are always at offset 0 or 2, so the same byte shift serves both widths.
   assign shifted = rdata >> {addr_lo, 3'b000};

   always_comb begin
      case (op)
         OP_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
         OP_LBU:  result = {24'd0, shifted[7:0]};
         OP_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
         OP_LHU:  result = {16'd0, shifted[15:0]};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_req_ctrl.sv
// MEM-stage data-memory request controller: issues one req/addr_ok/data_ok bus
// transaction per load/store, stalls the pipeline while it is outstanding, returns load data.
module mem_req_ctrl
   import mips_mem_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          validM,
   input  logic [5:0]    opM,
   input  logic [AW-1:0] addrM,
   input  logic [DW-1:0] writedataM,
   input  logic          addr_error_lw,
   input  logic          addr_error_sw,
   input  logic          flushM,
   input  logic          advanceM,
   output logic          data_req,
   output logic          data_wr,
   output logic [1:0]    data_size,
   output logic [AW-1:0] data_addr,
   output logic [DW-1:0] data_wdata,
   input  logic          data_addr_ok,
   input  logic          data_data_ok,
   input  logic [DW-1:0] data_rdata,
   output logic [DW-1:0] readdataM,
   output logic          stall_mem
);

   state_e        state_q, state_d;
   logic          discard_q, discard_d;
   logic [DW-1:0] readdata_q, readdata_d;
   logic [5:0]    op_q, op_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          mem_op;
   logic [DW-1:0] lane_wdata;
   logic [DW-1:0] aligned;
   logic [5:0]    out_op;

   assign mem_op = validM & (is_load(opM) | is_store(opM))
                 & ~addr_error_lw & ~addr_error_sw & ~flushM;

   always_comb begin
      case (opM)
         OP_SB:   lane_wdata = {4{writedataM[7:0]}};
         OP_SH:   lane_wdata = {2{writedataM[15:0]}};
         default: lane_wdata = writedataM;
      endcase
   end

   load_align u_load_align (
      .op      (op_q),
      .addr_lo (addr_q[1:0]),
      .rdata   (data_rdata),
      .result  (aligned)
   );

   always_comb begin
      state_d    = state_q;
      discard_d  = discard_q;
      readdata_d = readdata_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      data_req   = 1'b0;
      stall_mem  = 1'b0;
      out_op     = op_q;
      data_addr  = addr_q;
      data_wdata = wdata_q;
      case (state_q)
         S_IDLE: begin
            out_op     = opM;
            data_addr  = addrM;
            data_wdata = lane_wdata;
            discard_d  = 1'b0;
            if (mem_op) begin
               data_req  = 1'b1;
               stall_mem = 1'b1;
               // Capture the request so a flush of MEM cannot disturb it on the bus.
               op_d      = opM;
               addr_d    = addrM;
               wdata_d   = lane_wdata;
               state_d   = data_addr_ok ? S_WAIT : S_REQ;
            end else if (validM & (addr_error_lw | addr_error_sw)) begin
               readdata_d = '0;
            end
         end
         S_REQ: begin
            data_req  = 1'b1;
            stall_mem = 1'b1;
            if (flushM) discard_d = 1'b1;
            if (data_addr_ok) state_d = S_WAIT;
         end
         S_WAIT: begin
            stall_mem = ~data_data_ok;
            if (flushM) discard_d = 1'b1;
            if (data_data_ok) begin
               if (discard_q | flushM) begin
                  discard_d = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  if (is_load(op_q)) readdata_d = aligned;
                  state_d = advanceM ? S_IDLE : S_DONE;
               end
            end
         end
         default: begin
            if (advanceM) state_d = S_IDLE;
         end
      endcase
      data_wr   = is_store(out_op);
      data_size = op_size(out_op);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         discard_q  <= 1'b0;
         readdata_q <= '0;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         discard_q  <= discard_d;
         readdata_q <= readdata_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign readdataM = readdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed cases followed by randomized
// load/store traffic against a transaction-level reference model and bus responder.
module tb_mem_req_ctrl;

   localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001, LHU = 6'b100101;
   localparam logic [5:0] LW = 6'b100011, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
   localparam logic [5:0] NOP = 6'b000000;

   logic        clk;
   logic        rst;
   logic        validM;
   logic [5:0]  opM;
   logic [31:0] addrM;
   logic [31:0] writedataM;
   logic        addr_error_lw;
   logic        addr_error_sw;
   logic        flushM;
   logic        advanceM;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic [31:0] readdataM;
   logic        stall_mem;

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;
   logic [31:0] model_rd;

   mem_req_ctrl #(.AW(32), .DW(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .validM        (validM),
      .opM           (opM),
      .addrM         (addrM),
      .writedataM    (writedataM),
      .addr_error_lw (addr_error_lw),
      .addr_error_sw (addr_error_sw),
      .flushM        (flushM),
      .advanceM      (advanceM),
      .data_req      (data_req),
      .data_wr       (data_wr),
      .data_size     (data_size),
      .data_addr     (data_addr),
      .data_wdata    (data_wdata),
      .data_addr_ok  (data_addr_ok),
      .data_data_ok  (data_data_ok),
      .data_rdata    (data_rdata),
      .readdataM     (readdataM),
      .stall_mem     (stall_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit op_is_load(input logic [5:0] op);
      return op == LB || op == LBU || op == LH || op == LHU || op == LW;
   endfunction

   function automatic bit op_is_store(input logic [5:0] op);
      return op == SB || op == SH || op == SW;
   endfunction

   function automatic logic [1:0] exp_size(input logic [5:0] op);
      if (op == LB || op == LBU || op == SB) return 2'd0;
      if (op == LH || op == LHU || op == SH) return 2'd1;
      return 2'd2;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] wd);
      if (op == SB) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      if (op == SH) return {wd[15:0], wd[15:0]};
      return wd;
   endfunction

   function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [1:0] a, input logic [31:0] rd);
      int idx;
      logic [7:0]  b;
      logic [15:0] h;
      idx = int'(a);
      b = rd[idx*8 +: 8];
      h = rd[(idx/2)*16 +: 16];
      case (op)
         LB:      return {{24{b[7]}}, b};
         LBU:     return {24'd0, b};
         LH:      return {{16{h[15]}}, h};
         LHU:     return {16'd0, h};
         default: return rd;
      endcase
   endfunction

   task automatic idle_inputs();
      validM        = 1'b0;
      opM           = NOP;
      addr_error_lw = 1'b0;
      addr_error_sw = 1'b0;
      flushM        = 1'b0;
      advanceM      = 1'b0;
      data_addr_ok  = 1'b0;
      data_data_ok  = 1'b0;
   endtask

   // One MEM-stage instruction. aok: cycles until addr_ok; dok: cycles from addr_ok to data_ok;
   // fl_cyc: cycle index of a mid-transaction flush (-1 none); done_hold: cycles advanceM stays low after data_ok.
   task automatic do_instr(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input bit elw, input bit esw, input bit fl_idle,
                           input int aok, input int dok, input int fl_cyc, input int done_hold,
                           input logic [31:0] rd);
      bit is_ld, is_st, memop, accepted, finished, discard;
      int cyc, acc_cyc;
      is_ld = op_is_load(op);
      is_st = op_is_store(op);
      memop = (is_ld || is_st) && !elw && !esw && !fl_idle;
      n_txn++;
      $display("txn %0d op=%b addr=%h wd=%h elw=%0d esw=%0d fl_idle=%0d aok=%0d dok=%0d fl=%0d hold=%0d rd=%h",
               n_txn, op, addr, wd, elw, esw, fl_idle, aok, dok, fl_cyc, done_hold, rd);
      @(posedge clk); #1;
      validM = 1'b1; opM = op; addrM = addr; writedataM = wd;
      addr_error_lw = elw; addr_error_sw = esw; flushM = fl_idle;
      advanceM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      if (!memop) begin
         advanceM = 1'b1;
         @(negedge clk);
         check("noreq_req", 32'(data_req), 32'd0);
         check("noreq_stall", 32'(stall_mem), 32'd0);
         if (elw || esw) model_rd = 32'd0;
      end else begin
         accepted = 0; finished = 0; discard = 0; cyc = 0; acc_cyc = 0;
         while (!finished && cyc < 40) begin
            if (cyc > 0) begin
               @(posedge clk); #1;
            end
            data_addr_ok = !accepted && cyc == aok;
            data_data_ok = accepted && cyc == acc_cyc + dok;
            data_rdata   = data_data_ok ? rd : $urandom;
            flushM       = (cyc > 0) && (cyc == fl_cyc);
            if (flushM) discard = 1;
            if (discard) begin
               // A flushed MEM stage no longer holds this instruction; the bus request must not follow it.
               opM = NOP; addrM = $urandom; writedataM = $urandom; validM = 1'b0;
            end
            advanceM = data_data_ok && !discard && done_hold == 0;
            @(negedge clk);
            check("stall", 32'(stall_mem), 32'(!data_data_ok));
            check("req", 32'(data_req), 32'(!accepted));
            if (!accepted) begin
               check("wr", 32'(data_wr), 32'(is_st));
               check("size", 32'(data_size), 32'(exp_size(op)));
               check("addr", data_addr, addr);
               if (is_st) check("wdata", data_wdata, exp_wdata(op, wd));
            end
            if (data_addr_ok) begin
               accepted = 1;
               acc_cyc  = cyc;
            end
            if (data_data_ok) finished = 1;
            cyc++;
         end
         if (!finished) check("timeout", 32'd0, 32'd1);
         if (!discard && is_ld) model_rd = exp_load(op, addr[1:0], rd);
         if (!discard) begin
            for (int k = 0; k < done_hold; k++) begin
               @(posedge clk); #1;
               data_data_ok = 1'b0;
               data_addr_ok = 1'b0;
               advanceM     = (k == done_hold - 1);
               @(negedge clk);
               check("done_stall", 32'(stall_mem), 32'd0);
               check("done_req", 32'(data_req), 32'd0);
               check("done_rd", readdataM, model_rd);
            end
         end
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("rdata", readdataM, model_rd);
      check("idle_stall", 32'(stall_mem), 32'd0);
      check("idle_req", 32'(data_req), 32'd0);
   endtask

   initial begin
      logic [5:0] ops [9];
      logic [5:0] op;
      logic [31:0] addr;
      bit elw, esw, fl_idle;
      int aok, dok, fl_cyc, hold;
      ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, NOP};
      idle_inputs();
      rst = 1'b1; addrM = '0; writedataM = '0; data_rdata = '0;
      model_rd = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_req", 32'(data_req), 32'd0);
      check("rst_stall", 32'(stall_mem), 32'd0);
      check("rst_rd", readdataM, 32'd0);

      do_instr(LW,  32'h1000, 32'h0, 0, 0, 0, 0, 1, -1, 0, 32'hDEADBEEF);
      do_instr(LB,  32'h1003, 32'h0, 0, 0, 0, 0, 1, -1, 0, 32'h80FF0000);
      check("lb_sext", readdataM, 32'hFFFFFF80);
      do_instr(LBU, 32'h1003, 32'h0, 0, 0, 0, 1, 2, -1, 0, 32'h80FF0000);
      check("lbu_zext", readdataM, 32'h00000080);
      do_instr(SH,  32'h2002, 32'h1234ABCD, 0, 0, 0, 0, 1, -1, 0, 32'h0);
      do_instr(LW,  32'h1001, 32'h0, 1, 0, 0, 0, 1, -1, 0, 32'h0);
      do_instr(LW,  32'h1000, 32'h0, 0, 0, 0, 0, 1, -1, 0, 32'h13579BDF);
      do_instr(LW,  32'h3000, 32'h0, 0, 0, 0, 3, 2, 4, 0, 32'hCAFEF00D);
      do_instr(LH,  32'h3002, 32'h0, 0, 0, 0, 3, 2, 1, 0, 32'h8001FFFF);
      do_instr(LHU, 32'h3002, 32'h0, 0, 0, 0, 1, 2, -1, 3, 32'h8001FFFF);
      do_instr(LW,  32'h4000, 32'h0, 0, 0, 1, 0, 1, -1, 0, 32'h0);

      // Reset while a load is waiting for data_ok; a late data_ok must be ignored.
      @(posedge clk); #1;
      validM = 1'b1; opM = LW; addrM = 32'h5000; data_addr_ok = 1'b1;
      @(posedge clk); #1;
      idle_inputs(); rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h55AA55AA;
      model_rd = 32'd0;
      @(negedge clk);
      check("midrst_stall", 32'(stall_mem), 32'd0);
      check("midrst_req", 32'(data_req), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("midrst_rd", readdataM, 32'd0);

      for (int n = 0; n < 250; n++) begin
         op = ops[$urandom_range(0, 8)];
         addr = $urandom & 32'hFFFF_FFFC;
         elw = 0; esw = 0;
         if (op == LB || op == LBU || op == SB) addr[1:0] = 2'($urandom_range(0, 3));
         else if (op == LH || op == LHU || op == SH) addr[1] = 1'($urandom_range(0, 1));
         if (op != NOP && $urandom_range(0, 9) == 0 && exp_size(op) != 2'd0) begin
            addr[0] = 1'b1;
            if (op_is_load(op)) elw = 1; else esw = 1;
         end
         fl_idle = ($urandom_range(0, 9) == 0);
         aok = $urandom_range(0, 3);
         dok = $urandom_range(1, 3);
         fl_cyc = -1;
         if ($urandom_range(0, 3) == 0 && aok + dok - 1 >= 1) fl_cyc = $urandom_range(1, aok + dok - 1);
         hold = $urandom_range(0, 2);
         do_instr(op, addr, $urandom, elw, esw, fl_idle, aok, dok, fl_cyc, hold, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
